// File: rtl/wb_merge_if.sv
// Bundle of the write-back merge signals: pipeline write request, MDU
// result handshake, register-file write port, and decode interlock lookup.
// The slave modport is the merge stage; the master modport is its
// surroundings (pipeline, MDU, decode).
interface wb_merge_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   // pipeline write-back
   logic          pipe_we;
   logic [4:0]    pipe_waddr;
   logic [31:0]   pipe_wdata;

   // MDU result handshake
   logic          mdu_valid;
   logic          mdu_ready;
   logic [4:0]    mdu_waddr;
   logic [31:0]   mdu_wdata;

   // register-file write port
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;

   // decode interlock and status
   logic [4:0]    raddr1;
   logic [4:0]    raddr2;
   logic          pend1;
   logic          pend2;
   logic          pipe_stall;
   logic [CW-1:0] fifo_count;

   modport slave (
      input  pipe_we, pipe_waddr, pipe_wdata,
      input  mdu_valid, mdu_waddr, mdu_wdata,
      output mdu_ready,
      output rf_we, rf_waddr, rf_wdata,
      input  raddr1, raddr2,
      output pend1, pend2, pipe_stall, fifo_count
   );

   modport master (
      output pipe_we, pipe_waddr, pipe_wdata,
      output mdu_valid, mdu_waddr, mdu_wdata,
      input  mdu_ready,
      input  rf_we, rf_waddr, rf_wdata,
      output raddr1, raddr2,
      input  pend1, pend2, pipe_stall, fifo_count
   );
endinterface

// File: rtl/wb_merge.sv
// Write-back merge stage: sole driver of the register-file write port.
// Pipeline writes always win the slot; MDU results are buffered in a small
// FIFO and drained in acceptance order whenever the pipeline leaves the slot
// free. A starvation counter asks the pipeline to back off so the FIFO head
// cannot wait forever. Pending flags let decode interlock on registers whose
// MDU result has not reached the register file yet.
module wb_merge #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic         clk,
   input  logic         rst,
   wb_merge_if.slave    bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   // FIFO storage (data only, never reset) and control state
   logic [4:0]    q_addr [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] starve;

   // register-file write stage
   logic          we_p1;
   logic [4:0]    waddr_p1;
   logic [31:0]   wdata_p1;

   // slot decisions for the coming edge
   logic          ready;
   logic          accept;
   logic          pipe_ok;
   logic          mdu_ok;
   logic          fifo_ne;
   logic          do_pop;
   logic          do_cut;
   logic          do_push;

   // entry occupancy and pending lookup
   logic          live [DEPTH];
   logic          pend1;
   logic          pend2;

   // Starvation counter increment that sticks at the limit, so a pipeline
   // ignoring pipe_stall cannot wrap the counter and drop the request.
   function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
      if (v == LIMIT)
         return v;
      else
         return v + SW'(1);
   endfunction

   // Ready depends only on occupancy, never on mdu_valid, so a full FIFO
   // cannot take a result even on an edge where it pops.
   assign ready   = (count != FULL);
   assign accept  = bus.mdu_valid & ready;
   assign pipe_ok = bus.pipe_we & (bus.pipe_waddr != 5'd0);
   assign mdu_ok  = accept & (bus.mdu_waddr != 5'd0);
   assign fifo_ne = (count != '0);

   // Priority: pipeline, then FIFO head, then direct MDU cut-through.
   assign do_pop  = ~pipe_ok & fifo_ne;
   assign do_cut  = ~pipe_ok & ~fifo_ne & mdu_ok;
   assign do_push = mdu_ok & ~do_cut;

   // Mark which storage slots hold queued results (distance from head < count).
   always_comb begin
      logic [AW-1:0] offset;
      offset = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset  = AW'(i) - rd_ptr;
         live[i] = ({1'b0, offset} < count);
      end
   end

   // Look up both decode sources against every queued destination.
   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i] && (q_addr[i] == bus.raddr1) && (bus.raddr1 != 5'd0))
            pend1 = 1'b1;
         if (live[i] && (q_addr[i] == bus.raddr2) && (bus.raddr2 != 5'd0))
            pend2 = 1'b1;
      end
   end

   // Store an accepted MDU result at the tail.
   always_ff @(posedge clk) begin
      if (do_push) begin
         q_addr[wr_ptr] <= bus.mdu_waddr;
         q_data[wr_ptr] <= bus.mdu_wdata;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Count cycles the head is blocked by the pipeline; clear on pop or empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve <= '0;
      end else if (do_pop || !fifo_ne) begin
         starve <= '0;
      end else begin
         starve <= sat_inc(starve);
      end
   end

   // Register-file write stage: address/data hold when no write is issued.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_p1    <= 1'b0;
         waddr_p1 <= 5'd0;
         wdata_p1 <= 32'd0;
      end else if (pipe_ok) begin
         we_p1    <= 1'b1;
         waddr_p1 <= bus.pipe_waddr;
         wdata_p1 <= bus.pipe_wdata;
      end else if (do_pop) begin
         we_p1    <= 1'b1;
         waddr_p1 <= q_addr[rd_ptr];
         wdata_p1 <= q_data[rd_ptr];
      end else if (do_cut) begin
         we_p1    <= 1'b1;
         waddr_p1 <= bus.mdu_waddr;
         wdata_p1 <= bus.mdu_wdata;
      end else begin
         we_p1    <= 1'b0;
      end
   end

   assign bus.mdu_ready  = ready;
   assign bus.rf_we      = we_p1;
   assign bus.rf_waddr   = waddr_p1;
   assign bus.rf_wdata   = wdata_p1;
   assign bus.pend1      = pend1;
   assign bus.pend2      = pend2;
   assign bus.pipe_stall = (starve == LIMIT);
   assign bus.fifo_count = count;

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_merge;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   wb_merge_if #(.DEPTH(DEPTH)) bus ();

   wb_merge #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int          m_starve;
   bit          m_acc;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_pend(input logic [4:0] a);
      bit r;
      r = 1'b0;
      if (a != 5'd0)
         foreach (q[i])
            if (q[i].a == a) r = 1'b1;
      return r;
   endfunction

   function automatic void model_reset();
      q.delete();
      m_we     = 1'b0;
      m_waddr  = 5'd0;
      m_wdata  = 32'd0;
      m_starve = 0;
      m_acc    = 1'b0;
   endfunction

   // One rising edge of the merge rules, using the inputs present at the edge.
   function automatic void model_step();
      bit   acc, pipe_ok, ne, cut;
      ent_t e;
      acc     = bus.mdu_valid && (q.size() != DEPTH);
      m_acc   = acc;
      pipe_ok = bus.pipe_we && (bus.pipe_waddr != 5'd0);
      ne      = (q.size() != 0);
      cut     = 1'b0;
      if (pipe_ok) begin
         m_we = 1'b1; m_waddr = bus.pipe_waddr; m_wdata = bus.pipe_wdata;
         if (ne) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
         else    m_starve = 0;
      end else if (ne) begin
         e = q.pop_front();
         m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
         m_starve = 0;
      end else begin
         m_starve = 0;
         if (acc && bus.mdu_waddr != 5'd0) begin
            cut = 1'b1;
            m_we = 1'b1; m_waddr = bus.mdu_waddr; m_wdata = bus.mdu_wdata;
         end else begin
            m_we = 1'b0;
         end
      end
      if (acc && bus.mdu_waddr != 5'd0 && !cut) begin
         e.a = bus.mdu_waddr;
         e.d = bus.mdu_wdata;
         q.push_back(e);
      end
   endfunction

   always @(negedge rst) model_reset();

   // Compare process: advance the model on each edge, check 1 time unit later.
   always @(posedge clk) begin
      if (rst) model_step();
      else     model_reset();
      #1;
      chk("rf_we",      bus.rf_we,      m_we);
      chk("rf_waddr",   bus.rf_waddr,   m_waddr);
      chk("rf_wdata",   bus.rf_wdata,   m_wdata);
      chk("mdu_ready",  bus.mdu_ready,  q.size() != DEPTH);
      chk("fifo_count", bus.fifo_count, q.size());
      chk("pipe_stall", bus.pipe_stall, m_starve == LIMIT);
      chk("pend1",      bus.pend1,      m_pend(bus.raddr1));
      chk("pend2",      bus.pend2,      m_pend(bus.raddr2));
   end

   task automatic edge_();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.pipe_we = 1'b0; bus.pipe_waddr = 5'd0; bus.pipe_wdata = 32'd0;
      bus.mdu_valid = 1'b0; bus.mdu_waddr = 5'd0; bus.mdu_wdata = 32'd0;
      bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
   endtask

   int          e;
   logic [4:0]  got[$];

   initial begin
      idle_inputs();
      model_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) edge_();
      #3 rst = 1'b1;

      // reset release with idle inputs
      repeat (3) begin
         edge_();
         chk("idle_rf_we", bus.rf_we, 1'b0);
         chk("idle_rf_waddr", bus.rf_waddr, 5'd0);
         chk("idle_rf_wdata", bus.rf_wdata, 32'd0);
         chk("idle_ready", bus.mdu_ready, 1'b1);
         chk("idle_count", bus.fifo_count, 3'd0);
      end

      // cut-through
      bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd5; bus.mdu_wdata = 32'h1234;
      bus.raddr1 = 5'd5;
      edge_();
      chk("cut_we", bus.rf_we, 1'b1);
      chk("cut_waddr", bus.rf_waddr, 5'd5);
      chk("cut_wdata", bus.rf_wdata, 32'h1234);
      chk("cut_count", bus.fifo_count, 3'd0);
      chk("cut_pend", bus.pend1, 1'b0);
      bus.mdu_valid = 1'b0;
      edge_();
      chk("cut_after_we", bus.rf_we, 1'b0);
      chk("cut_hold_waddr", bus.rf_waddr, 5'd5);

      // contention and starvation
      bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'hA;
      bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd7; bus.mdu_wdata = 32'hB;
      bus.raddr1 = 5'd7; bus.raddr2 = 5'd8;
      edge_(); e = 1;
      chk("cont_pipe_waddr", bus.rf_waddr, 5'd3);
      chk("cont_count1", bus.fifo_count, 3'd1);
      bus.mdu_waddr = 5'd8; bus.mdu_wdata = 32'hC;
      edge_(); e = 2;
      chk("cont_count2", bus.fifo_count, 3'd2);
      chk("cont_pend7", bus.pend1, 1'b1);
      chk("cont_pend8", bus.pend2, 1'b1);
      chk("cont_nostall", bus.pipe_stall, 1'b0);
      bus.mdu_valid = 1'b0;
      while (bus.pipe_stall !== 1'b1 && e < 20) begin
         edge_();
         e++;
      end
      chk("stall_edge", e, 9);
      bus.pipe_we = 1'b0;
      edge_();
      chk("drain1_waddr", bus.rf_waddr, 5'd7);
      chk("drain1_wdata", bus.rf_wdata, 32'hB);
      chk("drain1_pend7", bus.pend1, 1'b0);
      chk("drain1_pend8", bus.pend2, 1'b1);
      chk("drain1_stall", bus.pipe_stall, 1'b0);
      edge_();
      chk("drain2_waddr", bus.rf_waddr, 5'd8);
      chk("drain2_wdata", bus.rf_wdata, 32'hC);
      chk("drain2_count", bus.fifo_count, 3'd0);
      edge_();
      chk("drain_idle_we", bus.rf_we, 1'b0);

      // full FIFO, fifth result held then accepted
      bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'hA;
      for (int i = 0; i < 4; i++) begin
         bus.mdu_valid = 1'b1;
         bus.mdu_waddr = 5'(10 + i);
         bus.mdu_wdata = 32'h100 + 32'(i);
         edge_();
      end
      chk("full_count", bus.fifo_count, 3'd4);
      chk("full_ready", bus.mdu_ready, 1'b0);
      bus.mdu_waddr = 5'd14; bus.mdu_wdata = 32'h104;
      repeat (2) edge_();
      chk("full_hold_count", bus.fifo_count, 3'd4);
      bus.pipe_we = 1'b0;
      got.delete();
      for (int k = 0; k < 8; k++) begin
         edge_();
         if (bus.rf_we === 1'b1) got.push_back(bus.rf_waddr);
         if (m_acc) bus.mdu_valid = 1'b0;
      end
      chk("full_drain_len", got.size(), 5);
      for (int k = 0; k < 5 && k < got.size(); k++)
         chk("full_drain_order", got[k], 5'(10 + k));
      chk("full_empty", bus.fifo_count, 3'd0);

      // register 0 is never written
      bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd0; bus.pipe_wdata = 32'hFFFF;
      bus.mdu_valid = 1'b1; bus.mdu_waddr = 5'd0; bus.mdu_wdata = 32'h55;
      bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
      chk("r0_ready", bus.mdu_ready, 1'b1);
      edge_();
      chk("r0_we", bus.rf_we, 1'b0);
      chk("r0_hold_waddr", bus.rf_waddr, 5'd14);
      chk("r0_count", bus.fifo_count, 3'd0);
      chk("r0_pend", bus.pend1, 1'b0);
      idle_inputs();
      edge_();
      chk("r0_idle_we", bus.rf_we, 1'b0);

      // async reset with three entries queued
      bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'hA;
      bus.raddr1 = 5'd21; bus.raddr2 = 5'd22;
      for (int i = 0; i < 3; i++) begin
         bus.mdu_valid = 1'b1;
         bus.mdu_waddr = 5'(20 + i);
         bus.mdu_wdata = 32'h200 + 32'(i);
         edge_();
      end
      chk("rst_pre_count", bus.fifo_count, 3'd3);
      chk("rst_pre_pend", bus.pend1, 1'b1);
      chk("rst_pre_we", bus.rf_we, 1'b1);
      bus.mdu_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_we", bus.rf_we, 1'b0);
      chk("rst_count", bus.fifo_count, 3'd0);
      chk("rst_pend1", bus.pend1, 1'b0);
      chk("rst_pend2", bus.pend2, 1'b0);
      chk("rst_ready", bus.mdu_ready, 1'b1);
      chk("rst_stall", bus.pipe_stall, 1'b0);
      idle_inputs();
      edge_();
      #3 rst = 1'b1;
      repeat (3) begin
         edge_();
         chk("post_rst_we", bus.rf_we, 1'b0);
         chk("post_rst_count", bus.fifo_count, 3'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Write-back merge stage directly upstream of the register file; sole driver of the register file's write enable, write address and write data.
- Merges two sources:
  - the in-order pipeline write-back (single cycle, never back-pressured);
  - a long-latency unit (mul/div, MDU) delivering results through a valid/ready handshake.
- MDU results wait in a small FIFO until a free write slot.
- Exposes pending-write flags so decode can interlock on registers whose MDU result is not yet written.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before pipe_stall asserts.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- pipe_we  in  1  pipeline write request this cycle
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  32  pipeline write data
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  merge can accept MDU result
- mdu_waddr  in  5  MDU destination register
- mdu_wdata  in  32  MDU result data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- raddr1  in  5  decode source register 1 (for pending lookup)
- raddr2  in  5  decode source register 2
- pend1  out  1  raddr1 has a queued, unwritten MDU result
- pend2  out  1  raddr2 has a queued, unwritten MDU result
- pipe_stall  out  1  request pipeline to hold off write-back next cycle
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, fifo_count=0, starve counter=0.
  - Outputs: mdu_ready=1, pipe_stall=0, pend1=pend2=0.
  - A reset mid-operation discards all queued entries; no write is issued on the reset-release edge.
- Write-slot arbitration, evaluated each rising edge, first match wins:
  1. pipe_we=1 and pipe_waddr!=0: issue pipe write.
  2. FIFO non-empty: pop head and issue it.
  3. MDU accept this cycle (mdu_valid & mdu_ready), FIFO empty, mdu_waddr!=0: cut-through, issue MDU data directly without enqueue.
  4. Otherwise rf_we<=0; rf_waddr and rf_wdata hold their previous values.
- Issue latency: one cycle. "Issue" means rf_we<=1, rf_waddr<=addr, rf_wdata<=data on that edge.
- Register 0 is never written:
  - pipe write to address 0 is treated as pipe_we=0;
  - an accepted MDU result to address 0 completes the handshake and is discarded (not enqueued, not issued).
- Handshake:
  - mdu_ready = (fifo_count != DEPTH), combinational from state only; it does not depend on mdu_valid.
  - Transfer occurs on an edge where mdu_valid & mdu_ready.
  - An accepted result that is not cut through and has waddr!=0 is pushed at the tail.
- Simultaneous push and pop: both happen, count unchanged, ordering preserved.
- Full FIFO: mdu_ready=0, so no push. A pop on that edge lowers the count; ready rises the following cycle (no same-cycle pass-through when full).
- Ordering: MDU results are written strictly in acceptance order. The pipeline write is not ordered against the FIFO.
- WAW hazard rule: decode must not issue an instruction reading or writing a register whose pend flag is set. This block does not detect WAW.
- pend1/pend2 (combinational):
  - pendN=1 iff raddrN!=0 and some valid FIFO entry has waddr==raddrN.
  - An entry popped on an edge clears its contribution after that edge.
  - A cut-through result is never pending.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and rule 1 wins; it clears on any pop or when the FIFO is empty.
  - pipe_stall=1 (combinational) when counter==STARVE_LIMIT.
  - Contract: the pipeline drives pipe_we=0 in any cycle pipe_stall=1, so rule 2 pops.
  - If the contract is violated, the pipe write still wins, the counter saturates, and no data is lost.
- fifo_count wraps never: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count saturates architecturally at DEPTH via ready.

Test Plan:
- Reset release, idle inputs: rf_we=0, rf_waddr=0, rf_wdata=0, mdu_ready=1, fifo_count=0 on every cycle.
- Cut-through: pipe_we=0, MDU valid waddr=5, wdata=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; fifo_count stays 0; pend never set.
- Contention:
  - Pipe writes r3=0xA every cycle while MDU delivers r7=0xB then r8=0xC.
  - Both MDU results are queued (count=2, pend for r7 and r8).
  - pipe_stall=1 after 8 blocked cycles; with pipe_we=0, r7 is written and then r8, in that order.
- Full FIFO: pipe_we=1 every cycle, 4 MDU pushes -> fifo_count=4 and mdu_ready=0; a 5th valid result is held by the MDU until a pop, then accepted, with no loss or reordering.
- Register 0: pipe write r0=0xFFFF and MDU result r0=0x55 -> rf_we stays 0, the MDU handshake completes, fifo_count=0, pend1=0 with raddr1=0.
- Async reset with 3 entries queued: rst low mid-cycle -> rf_we drops immediately, fifo_count=0, pend flags 0; after release no stale write occurs.
